// File: rtl/spm_banked.sv
// rtl/spm_banked.sv - word-interleaved banked scratchpad shared by IF and MEM ports
// Same-bank collisions are resolved by a two-state round-robin arbiter that stalls the loser via rdy.
module spm_banked #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12,
   parameter int BANKS  = 2,
   localparam int BE_W  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] if_spm_addr,
   input  logic              if_spm_as_,
   input  logic              if_spm_rw,
   input  logic [BE_W-1:0]   if_spm_be,
   input  logic [DATA_W-1:0] if_spm_wr_data,
   output logic              if_spm_rdy,
   output logic [DATA_W-1:0] if_spm_rd_data,
   output logic              if_spm_rd_vld,
   input  logic [ADDR_W-1:0] mem_spm_addr,
   input  logic              mem_spm_as_,
   input  logic              mem_spm_rw,
   input  logic [BE_W-1:0]   mem_spm_be,
   input  logic [DATA_W-1:0] mem_spm_wr_data,
   output logic              mem_spm_rdy,
   output logic [DATA_W-1:0] mem_spm_rd_data,
   output logic              mem_spm_rd_vld
);

   localparam int BS    = $clog2(BANKS);
   localparam int BI_W  = (BS == 0) ? 1 : BS;
   localparam int ROW_W = ADDR_W - BS;

   localparam logic ENABLE_ = 1'b0;
   localparam logic READ    = 1'b1;
   localparam logic WRITE   = 1'b0;

   localparam logic [0:0] PRI_MEM = 1'b0;
   localparam logic [0:0] PRI_IF  = 1'b1;

   logic [DATA_W-1:0] ram [BANKS][2**ROW_W];
   logic [0:0]        pri;

   logic              if_req, mem_req, conflict;
   logic              if_acc, mem_acc, if_wr, mem_wr;
   logic [BI_W-1:0]   if_bank, mem_bank;
   logic [ROW_W-1:0]  if_row, mem_row;

   function automatic logic [BI_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
      if (BS == 0) return '0;
      else         return a[BI_W-1:0];
   endfunction

   assign if_bank  = bank_of(if_spm_addr);
   assign mem_bank = bank_of(mem_spm_addr);
   assign if_row   = if_spm_addr[ADDR_W-1:BS];
   assign mem_row  = mem_spm_addr[ADDR_W-1:BS];

   assign if_req   = (if_spm_as_ == ENABLE_);
   assign mem_req  = (mem_spm_as_ == ENABLE_);
   assign conflict = if_req && mem_req && (if_bank == mem_bank);

   // Idle ports still see rdy=1; only reset or a lost conflict drops it.
   assign if_spm_rdy  = !reset && (!conflict || (pri == PRI_IF));
   assign mem_spm_rdy = !reset && (!conflict || (pri == PRI_MEM));

   assign if_acc  = if_req && if_spm_rdy;
   assign mem_acc = mem_req && mem_spm_rdy;
   assign if_wr   = if_acc && (if_spm_rw == WRITE);
   assign mem_wr  = mem_acc && (mem_spm_rw == WRITE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         pri <= PRI_MEM;
      else if (conflict) pri <= (pri == PRI_MEM) ? PRI_IF : PRI_MEM;
   end

   // Accepted accesses never share a bank, so the two writes always hit different entries.
   always_ff @(posedge clk) begin
      for (int i = 0; i < BE_W; i++) begin
         if (if_wr && if_spm_be[i])
            ram[if_bank][if_row][8*i +: 8] <= if_spm_wr_data[8*i +: 8];
         if (mem_wr && mem_spm_be[i])
            ram[mem_bank][mem_row][8*i +: 8] <= mem_spm_wr_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_spm_rd_data  <= '0;
         if_spm_rd_vld   <= 1'b0;
         mem_spm_rd_data <= '0;
         mem_spm_rd_vld  <= 1'b0;
      end else begin
         if_spm_rd_vld  <= if_acc && (if_spm_rw == READ);
         mem_spm_rd_vld <= mem_acc && (mem_spm_rw == READ);
         if (if_acc && (if_spm_rw == READ))
            if_spm_rd_data <= ram[if_bank][if_row];
         if (mem_acc && (mem_spm_rw == READ))
            mem_spm_rd_data <= ram[mem_bank][mem_row];
      end
   end

endmodule

// File: tb/tb_spm_banked.sv
// tb/tb_spm_banked.sv - directed self-checking bench for spm_banked (DATA_W=32, ADDR_W=12, BANKS=2)
module tb_spm_banked;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] if_addr, mem_addr;
   logic        if_as_, if_rw, mem_as_, mem_rw;
   logic [3:0]  if_be, mem_be;
   logic [31:0] if_wd, mem_wd;
   logic        if_rdy, if_vld, mem_rdy, mem_vld;
   logic [31:0] if_rd, mem_rd;

   int checks   = 0;
   int failures = 0;

   spm_banked #(.DATA_W(32), .ADDR_W(12), .BANKS(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .if_spm_addr     (if_addr),
      .if_spm_as_      (if_as_),
      .if_spm_rw       (if_rw),
      .if_spm_be       (if_be),
      .if_spm_wr_data  (if_wd),
      .if_spm_rdy      (if_rdy),
      .if_spm_rd_data  (if_rd),
      .if_spm_rd_vld   (if_vld),
      .mem_spm_addr    (mem_addr),
      .mem_spm_as_     (mem_as_),
      .mem_spm_rw      (mem_rw),
      .mem_spm_be      (mem_be),
      .mem_spm_wr_data (mem_wd),
      .mem_spm_rdy     (mem_rdy),
      .mem_spm_rd_data (mem_rd),
      .mem_spm_rd_vld  (mem_vld)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int a);
      return 32'hA5A5_0000 | 32'(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // rw: 1 = read, 0 = write
   task automatic drv_if(input logic as_, input logic rw, input int a,
                         input logic [3:0] be, input logic [31:0] d);
      if_as_ = as_; if_rw = rw; if_addr = 12'(a); if_be = be; if_wd = d;
   endtask

   task automatic drv_mem(input logic as_, input logic rw, input int a,
                          input logic [3:0] be, input logic [31:0] d);
      mem_as_ = as_; mem_rw = rw; mem_addr = 12'(a); mem_be = be; mem_wd = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      drv_if(1'b1, 1'b1, 0, 4'h0, 32'h0);
      drv_mem(1'b1, 1'b1, 0, 4'h0, 32'h0);
      #1;
      chk("rst_if_rdy",  32'(if_rdy),  32'h0);
      chk("rst_mem_rdy", 32'(mem_rdy), 32'h0);
      chk("rst_if_vld",  32'(if_vld),  32'h0);
      chk("rst_mem_rd",  mem_rd,       32'h0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("idle_if_rdy", 32'(if_rdy), 32'h1);

      // Preload 0x000..0x00F through MEM.
      for (int a = 0; a < 16; a++) begin
         drv_mem(1'b0, 1'b0, a, 4'hF, pat(a));
         tick();
      end

      // Back-to-back MEM reads with IF idle.
      for (int a = 0; a < 8; a++) begin
         drv_mem(1'b0, 1'b1, a, 4'h0, 32'h0);
         #1;
         chk($sformatf("b2b_rdy_%0d", a), 32'(mem_rdy), 32'h1);
         tick();
         chk($sformatf("b2b_vld_%0d", a), 32'(mem_vld), 32'h1);
         chk($sformatf("b2b_dat_%0d", a), mem_rd, pat(a));
      end
      drv_mem(1'b1, 1'b1, 0, 4'h0, 32'h0);
      tick();
      chk("b2b_vld_clr", 32'(mem_vld), 32'h0);
      chk("b2b_dat_hold", mem_rd, pat(7));

      // Full-word write then IF read.
      drv_mem(1'b0, 1'b0, 'h004, 4'hF, 32'hDEAD_BEEF);
      tick();
      drv_mem(1'b1, 1'b1, 0, 4'h0, 32'h0);
      drv_if(1'b0, 1'b1, 'h004, 4'h0, 32'h0);
      #1;
      chk("t1_if_rdy", 32'(if_rdy), 32'h1);
      tick();
      chk("t1_if_dat", if_rd, 32'hDEAD_BEEF);
      chk("t1_if_vld", 32'(if_vld), 32'h1);
      drv_if(1'b1, 1'b1, 0, 4'h0, 32'h0);

      // Partial byte-enable write.
      drv_mem(1'b0, 1'b0, 'h004, 4'b0101, 32'h1122_3344);
      tick();
      chk("t2_wr_vld", 32'(mem_vld), 32'h0);
      drv_mem(1'b0, 1'b1, 'h004, 4'h0, 32'h0);
      tick();
      chk("t2_dat", mem_rd, 32'hDE22_BE44);
      chk("t2_vld", 32'(mem_vld), 32'h1);
      drv_mem(1'b1, 1'b1, 0, 4'h0, 32'h0);
      tick();

      // Same-bank conflicts alternate starting with MEM.
      drv_if(1'b0, 1'b1, 'h008, 4'h0, 32'h0);
      drv_mem(1'b0, 1'b1, 'h00A, 4'h0, 32'h0);
      #1;
      chk("t3_c1_mem_rdy", 32'(mem_rdy), 32'h1);
      chk("t3_c1_if_rdy",  32'(if_rdy),  32'h0);
      tick();
      chk("t3_c1_mem_dat", mem_rd, pat('h00A));
      chk("t3_c1_if_vld",  32'(if_vld), 32'h0);
      drv_mem(1'b0, 1'b1, 'h00C, 4'h0, 32'h0);
      #1;
      chk("t3_c2_if_rdy",  32'(if_rdy),  32'h1);
      chk("t3_c2_mem_rdy", 32'(mem_rdy), 32'h0);
      tick();
      chk("t3_c2_if_dat",  if_rd, pat('h008));
      chk("t3_c2_mem_vld", 32'(mem_vld), 32'h0);
      drv_if(1'b0, 1'b1, 'h00E, 4'h0, 32'h0);
      #1;
      chk("t3_c3_mem_rdy", 32'(mem_rdy), 32'h1);
      chk("t3_c3_if_rdy",  32'(if_rdy),  32'h0);
      tick();
      chk("t3_c3_mem_dat", mem_rd, pat('h00C));
      drv_if(1'b1, 1'b1, 0, 4'h0, 32'h0);
      drv_mem(1'b1, 1'b1, 0, 4'h0, 32'h0);
      tick();

      // Different banks proceed together.
      drv_if(1'b0, 1'b1, 'h008, 4'h0, 32'h0);
      drv_mem(1'b0, 1'b0, 'h009, 4'hF, 32'hCAFE_F00D);
      #1;
      chk("t4_if_rdy",  32'(if_rdy),  32'h1);
      chk("t4_mem_rdy", 32'(mem_rdy), 32'h1);
      tick();
      chk("t4_if_dat", if_rd, pat('h008));
      drv_mem(1'b1, 1'b1, 0, 4'h0, 32'h0);
      drv_if(1'b0, 1'b1, 'h009, 4'h0, 32'h0);
      tick();
      chk("t4_rd_009", if_rd, 32'hCAFE_F00D);
      drv_if(1'b0, 1'b1, 'h008, 4'h0, 32'h0);
      tick();
      chk("t4_rd_008", if_rd, pat('h008));
      chk("t4_vld", 32'(if_vld), 32'h1);

      // Reset while a read is pending.
      drv_if(1'b0, 1'b1, 'h004, 4'h0, 32'h0);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_if_vld",  32'(if_vld),  32'h0);
      chk("t5_if_dat",  if_rd,        32'h0);
      chk("t5_if_rdy",  32'(if_rdy),  32'h0);
      chk("t5_mem_rdy", 32'(mem_rdy), 32'h0);
      drv_if(1'b1, 1'b1, 0, 4'h0, 32'h0);
      tick();
      reset = 1'b0;
      tick();
      chk("t5_post_vld", 32'(if_vld), 32'h0);
      drv_if(1'b0, 1'b1, 'h004, 4'h0, 32'h0);
      drv_mem(1'b0, 1'b1, 'h006, 4'h0, 32'h0);
      #1;
      chk("t5_arb_mem_rdy", 32'(mem_rdy), 32'h1);
      chk("t5_arb_if_rdy",  32'(if_rdy),  32'h0);
      tick();
      drv_mem(1'b1, 1'b1, 0, 4'h0, 32'h0);
      #1;
      chk("t5_if_rdy2", 32'(if_rdy), 32'h1);
      tick();
      chk("t5_rd_004", if_rd, 32'hDE22_BE44);
      chk("t5_mem_006", mem_rd, pat('h006));
      drv_if(1'b1, 1'b1, 0, 4'h0, 32'h0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
